// File: rtl/mem_map_pkg.sv
// Memory map of the MEM stage: peripheral offsets, TCON bit positions and address decode.
// Optional systick counter lives behind MEM_STAGE_SYSTICK_EN (see mem_stage_bus).
package mem_map_pkg;

  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_LED     = 32'h0000_000C;
  localparam logic [31:0] OFF_DIGI    = 32'h0000_0010;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_SYSTICK
  } sel_e;

  // Byte lanes are ignored: the offset is masked to a word before matching.
  function automatic sel_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] ram_bytes);
    logic [31:0] off;
    sel_e        sel;
    off = (addr - base) & ~32'h3;
    sel = SEL_NONE;
    if (addr < ram_bytes) begin
      sel = SEL_RAM;
    end else begin
      case (off)
        OFF_TH:      sel = SEL_TH;
        OFF_TL:      sel = SEL_TL;
        OFF_TCON:    sel = SEL_TCON;
        OFF_LED:     sel = SEL_LED;
        OFF_DIGI:    sel = SEL_DIGI;
        OFF_SYSTICK: sel = SEL_SYSTICK;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// Load/store request bus from EX/MEM into the memory stage; read data returns in the same cycle.
interface mem_stage_bus_if;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_Address;
  logic [31:0] MEM_Write_Data;
  logic [31:0] MEM_Read_Data;

  modport master (
    output MEM_MemRead,
    output MEM_MemWrite,
    output MEM_Address,
    output MEM_Write_Data,
    input  MEM_Read_Data
  );

  modport slave (
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  MEM_Address,
    input  MEM_Write_Data,
    output MEM_Read_Data
  );
endinterface

// File: rtl/timer_unit.sv
// Reloading up-counter (TH/TL/TCON) with sticky overflow status and a registered irq.
// Software writes to TL beat the count; an overflow set beats a software clear of status.
module timer_unit
  import mem_map_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        st_q, st_d;
  logic        irq_q, irq_d;
  logic        ovf;

  always_comb begin
    ovf   = en_q && (tl_q == 32'hFFFF_FFFF);
    th_d  = th_we_i ? wdata_i : th_q;
    tl_d  = tl_q;
    en_d  = en_q;
    ie_d  = ie_q;
    st_d  = st_q;
    irq_d = st_q & ie_q;

    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (en_q) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end

    if (tcon_we_i) begin
      en_d = wdata_i[TCON_EN];
      ie_d = wdata_i[TCON_IE];
      if (!wdata_i[TCON_ST]) st_d = 1'b0;
    end
    // Set after clear so a coincident overflow is never lost.
    if (ovf && ie_q) st_d = 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      th_q  <= '0;
      tl_q  <= '0;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      st_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      th_q  <= th_d;
      tl_q  <= tl_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      st_q  <= st_d;
      irq_q <= irq_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = {st_q, ie_q, en_q};
  assign irq_o  = irq_q;

endmodule

// File: rtl/mem_stage_bus.sv
// MEM stage: decodes the ALU address to data RAM or the peripheral window; loads are combinational.
// Define MEM_STAGE_SYSTICK_EN to add the free-running systick counter at offset 0x14.
module mem_stage_bus
  import mem_map_pkg::*;
#(
  parameter int          RAM_ADDR_W  = 9,
  parameter int          RAM_DEPTH   = 512,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  mem_stage_bus_if.slave    bus,
  output logic [7:0]        led,
  output logic [11:0]       digi,
  output logic              irq
);

  localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);

  sel_e                  sel;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  wr;
  logic [31:0]           rd_val;

  logic [31:0] ram [RAM_DEPTH];

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;

  logic [31:0] th, tl;
  logic [2:0]  tcon;

  always_comb begin
    sel     = decode_addr(bus.MEM_Address, PERIPH_BASE, RAM_BYTES);
    ram_idx = bus.MEM_Address[RAM_ADDR_W+1:2];
    wr      = bus.MEM_MemWrite;
  end

  // RAM is not reset; a store presented while reset is high is dropped.
  always_ff @(posedge sysclk) begin
    if (wr && !reset && (sel == SEL_RAM)) ram[ram_idx] <= bus.MEM_Write_Data;
  end

  always_comb begin
    led_d  = (wr && sel == SEL_LED)  ? bus.MEM_Write_Data[7:0]  : led_q;
    digi_d = (wr && sel == SEL_DIGI) ? bus.MEM_Write_Data[11:0] : digi_q;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  timer_unit u_timer (
    .sysclk    (sysclk),
    .reset     (reset),
    .th_we_i   (wr && sel == SEL_TH),
    .tl_we_i   (wr && sel == SEL_TL),
    .tcon_we_i (wr && sel == SEL_TCON),
    .wdata_i   (bus.MEM_Write_Data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irq)
  );

`ifdef MEM_STAGE_SYSTICK_EN
  logic [31:0] tick_q, tick_d;

  // A write clears the counter and swallows that cycle's increment.
  always_comb tick_d = (wr && sel == SEL_SYSTICK) ? 32'd0 : tick_q + 32'd1;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end
`endif

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RAM:     rd_val = ram[ram_idx];
      SEL_TH:      rd_val = th;
      SEL_TL:      rd_val = tl;
      SEL_TCON:    rd_val = {29'b0, tcon};
      SEL_LED:     rd_val = {24'b0, led_q};
      SEL_DIGI:    rd_val = {20'b0, digi_q};
`ifdef MEM_STAGE_SYSTICK_EN
      SEL_SYSTICK: rd_val = tick_q;
`endif
      default:     rd_val = '0;
    endcase
    bus.MEM_Read_Data = bus.MEM_MemRead ? rd_val : 32'h0;
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule
